icache_data_ctrl: RTL and testbench

//  Front-end controller for the 16x256b OpenRAM I-cache data array (single RW port, byte wmask).

---
 rtl/icache_data_ctrl.sv | 137 +++++++++++++
 tb/tb_icache_data_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_data_ctrl.sv
// Front-end for the I-cache data SRAM: zero-fill sweep after reset, then one-access-per-cycle
// arbitration of refill writes against fetch reads, with a 2-entry response FIFO on dout.
module icache_data_ctrl #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned NUM_WMASKS    = 32,
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [NUM_WMASKS-1:0] wr_req_mask,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

  localparam int unsigned StreakW = $clog2(MAX_WR_STREAK + 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [StreakW-1:0]    streak_q, streak_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic                  fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [2];

  logic       push, pop, rd_ok, run, init_wr, rd_grant, wr_grant;
  logic [2:0] occupancy;

  assign rd_rsp_valid = (fifo_cnt_q != 2'd0);
  assign rd_rsp_data  = fifo_mem_q[fifo_rd_ptr_q];
  assign init_done    = (state_q == StRun) && !rst;
  assign rd_req_ready = rd_grant;
  assign wr_req_ready = wr_grant;

  // Occupancy counts the read already in the macro so a grant can never overflow the FIFO.
  always_comb begin
    push      = inflight_q;
    pop       = rd_rsp_valid && rd_rsp_ready;
    occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_ok     = (occupancy < 3'd2);
    run       = (state_q == StRun) && !rst;
    init_wr   = (state_q == StInit) && !rst;
    rd_grant  = run && rd_req_valid && rd_ok &&
                (!wr_req_valid || (streak_q == StreakW'(MAX_WR_STREAK)));
    wr_grant  = run && wr_req_valid && !rd_grant;
  end

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (init_wr) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = init_cnt_q;
    end else if (wr_grant) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = wr_req_mask;
      sram_addr0  = wr_req_addr;
      sram_din0   = wr_req_data;
    end else if (rd_grant) begin
      sram_csb0   = 1'b0;
      sram_addr0  = rd_req_addr;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    streak_d      = streak_q;
    inflight_d    = rd_grant;
    fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    fifo_rd_ptr_d = fifo_rd_ptr_q ^ pop;
    fifo_wr_ptr_d = fifo_wr_ptr_q ^ push;
    if (state_q == StInit) begin
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
      if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = StRun;
      end
    end
    if (!rd_req_valid || rd_grant) begin
      streak_d = '0;
    end else if (wr_grant && (streak_q != StreakW'(MAX_WR_STREAK))) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      streak_q      <= '0;
      inflight_q    <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      streak_q      <= streak_d;
      inflight_q    <= inflight_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
    end
  end

  // Macro dout is only valid around the edge after the read, so capture it there.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[fifo_wr_ptr_q] <= sram_dout0;
    end
  end

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Bench for icache_data_ctrl: behavioural SRAM macro plus a read-response scoreboard.
module tb_icache_data_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
  logic [3:0]   rd_req_addr, wr_req_addr, sram_addr0;
  logic [255:0] rd_rsp_data, wr_req_data, sram_din0, sram_dout0;
  logic         wr_req_valid, wr_req_ready, sram_csb0, sram_web0, init_done;
  logic [31:0]  wr_req_mask, sram_wmask0;

  logic [255:0] sram_mem  [16];
  logic [255:0] model_mem [16];
  logic [255:0] exp_q [$];
  logic [255:0] last_rsp;
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  icache_data_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_mask  (wr_req_mask),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_wmask0  (sram_wmask0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0),
    .init_done    (init_done)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single-port macro: writes land at the edge, reads present data after the edge.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 32; b++) begin
          if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
        end
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  // Scoreboard: expected data pushed on read handshake, compared on response pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else begin
      if (rd_rsp_valid && rd_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", rd_rsp_data, 256'hx);
        end else begin
          check_eq("rsp_data", rd_rsp_data, exp_q.pop_front());
          last_rsp = rd_rsp_data;
        end
      end
      if (rd_req_valid && rd_req_ready) exp_q.push_back(model_mem[rd_req_addr]);
      if (wr_req_valid && wr_req_ready) begin
        for (int b = 0; b < 32; b++) begin
          if (wr_req_mask[b]) model_mem[wr_req_addr][b*8 +: 8] = wr_req_data[b*8 +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check_eq("drain", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic check_sweep(input int i);
    check_eq("sweep_ctl", {251'd0, sram_csb0, sram_web0, rd_req_ready, wr_req_ready, init_done},
             256'd0);
    check_eq("sweep_addr", 256'(sram_addr0), 256'(i));
    check_eq("sweep_data", {254'd0, sram_wmask0 == '1, sram_din0 == '0}, 256'd3);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < 8; w++) sram_mem[i][w*32 +: 32] = $urandom;
    rst = 1'b1; rd_req_valid = 1'b1; wr_req_valid = 1'b1; rd_rsp_ready = 1'b1;
    rd_req_addr = 4'd0; wr_req_addr = 4'd0; wr_req_data = '0; wr_req_mask = '1;
    #1;
    check_eq("rst_ctl", {252'd0, sram_csb0, sram_web0, rd_req_ready, wr_req_ready}, 256'hC);
    tick();
    rst = 1'b0;
    // Zero-fill sweep, requests held high throughout
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin rd_req_valid = 1'b0; wr_req_valid = 1'b0; end
      #1;
      check_sweep(i);
      tick();
    end
    #1;
    check_eq("init_done", 256'(init_done), 256'd1);
    check_eq("rsp_idle", 256'(rd_rsp_valid), 256'd0);

    // Full-line write then read-back, response two cycles after the read grant
    tick();
    wr_req_valid = 1'b1; wr_req_addr = 4'd3; wr_req_data = {32{8'hA5}}; wr_req_mask = '1;
    #1;
    check_eq("wr3_ready", 256'({wr_req_ready, sram_csb0, sram_web0}), 256'd4);
    tick();
    wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 4'd3;
    #1;
    check_eq("rd3_ready", 256'({rd_req_ready, sram_csb0, sram_web0}), 256'd5);
    tick();
    rd_req_valid = 1'b0;
    #1;
    check_eq("rd3_lat1", 256'(rd_rsp_valid), 256'd0);
    tick();
    check_eq("rd3_lat2", 256'(rd_rsp_valid), 256'd1);
    drain();
    check_eq("rd3_data", last_rsp, {32{8'hA5}});

    // Byte-masked write
    wr_req_valid = 1'b1; wr_req_addr = 4'd5; wr_req_data = '1; wr_req_mask = 32'h1;
    tick();
    wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 4'd5;
    tick();
    rd_req_valid = 1'b0;
    drain();
    check_eq("rd5_data", last_rsp, 256'hFF);

    // Both requesters held: W,W,W,W,R repeating
    for (int k = 0; k < 15; k++) begin
      wr_req_valid = 1'b1; wr_req_addr = 4'(k); wr_req_mask = 32'(k * 32'h0101_0ff1 + 1);
      for (int w = 0; w < 8; w++) wr_req_data[w*32 +: 32] = $urandom;
      rd_req_valid = 1'b1; rd_req_addr = 4'(k * 7);
      #1;
      check_eq("arb_grant", 256'({rd_req_ready, wr_req_ready}),
               (k % 5 == 4) ? 256'd2 : 256'd1);
      tick();
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    drain();

    // Backpressure: third read stalls until a pop frees a slot
    rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 4'd1;
    #1; check_eq("bp_rd1", 256'(rd_req_ready), 256'd1);
    tick(); rd_req_addr = 4'd2;
    #1; check_eq("bp_rd2", 256'(rd_req_ready), 256'd1);
    tick(); rd_req_addr = 4'd3;
    #1; check_eq("bp_stall0", 256'(rd_req_ready), 256'd0);
    tick();
    #1; check_eq("bp_stall1", 256'(rd_req_ready), 256'd0);
    tick();
    #1; check_eq("bp_stall2", 256'({rd_req_ready, rd_rsp_valid}), 256'd1);
    rd_rsp_ready = 1'b1;
    #1; check_eq("bp_unstall", 256'(rd_req_ready), 256'd1);
    tick();
    rd_req_valid = 1'b0;
    drain();

    // Reset with one response buffered and the sweep restarting from line 0
    rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 4'd2;
    tick();
    rd_req_valid = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_valid", 256'(rd_rsp_valid), 256'd1);
    rst = 1'b1; rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    #1;
    check_eq("mid_rst_ctl", {252'd0, sram_csb0, sram_web0, rd_req_ready, wr_req_ready}, 256'hC);
    tick();
    rst = 1'b0; rd_req_valid = 1'b0; wr_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    #1;
    check_eq("post_rst_valid", 256'(rd_rsp_valid), 256'd0);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) #1;
      check_sweep(i);
      tick();
    end
    #1;
    check_eq("reinit_done", 256'(init_done), 256'd1);
    rd_req_valid = 1'b1; rd_req_addr = 4'd3;
    tick();
    rd_req_valid = 1'b0;
    drain();
    check_eq("post_rst_rd3", last_rsp, 256'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
